// File: rtl/car_wiper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : car_wiper_pkg
//  Description : Shared types for the wiper controller: FSM state encoding,
//                motor drive codes and the motor decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package car_wiper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WIPE = 3'd1,
        ST_GAP  = 3'd2,
        ST_WASH = 3'd3,
        ST_DRY  = 3'd4
    } wiper_state_t;

    localparam logic [1:0] MOT_OFF  = 2'b00;
    localparam logic [1:0] MOT_SLOW = 2'b01;
    localparam logic [1:0] MOT_FAST = 2'b10;

    // Washer and dry sweeps always run slow; only plain sweeps honour the latched speed
    function automatic logic [1:0] motor_code(input wiper_state_t st, input logic fast);
        logic [1:0] code;
        case (st)
            ST_WIPE: code = fast ? MOT_FAST : MOT_SLOW;
            ST_WASH: code = MOT_SLOW;
            ST_DRY:  code = MOT_SLOW;
            default: code = MOT_OFF;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wiper_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wiper_timer
//  Description : Loadable down-counter that stops at zero. One instance times
//                sweeps, intermittent gaps and dry sweeps in turn.
//  Revision    : 1.0  initial release
// ============================================================================
module wiper_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_value,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value = r_cnt;
    assign o_done  = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/car_wiper_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : car_wiper_ctrl
//  Description : Windscreen wiper controller with manual, single-sweep and
//                rain-sensing intermittent modes. Define WIPER_WASH_EN to
//                include the washer (WASH) and post-wash dry sweeps (DRY).
//  Revision    : 1.0  initial release
// ============================================================================
module car_wiper_ctrl
    import car_wiper_pkg::*;
#(
    parameter int SWEEP_CYC  = 64,
    parameter int RAIN_W     = 4,
    parameter int TH_SLOW    = 8,
    parameter int TH_FAST    = 12,
    parameter int GAP_STEP   = 32,
    parameter int DRY_SWEEPS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              auto_md,
    input  logic [1:0]        man_spd,
    input  logic [RAIN_W-1:0] rain,
    input  logic              wash,
    output logic [1:0]        motor,
    output logic              pump,
    output logic              busy
);

    // Timer holds "cycles remaining - 1", so the largest load is the longest gap or sweep minus one
    localparam int c_gap_max = (TH_SLOW - 1) * GAP_STEP;
    localparam int c_tmr_max = (c_gap_max > SWEEP_CYC) ? c_gap_max - 1 : SWEEP_CYC - 1;
    localparam int c_tw      = (c_tmr_max < 1) ? 1 : $clog2(c_tmr_max + 1);

    localparam logic [c_tw-1:0]   c_sweep_val = c_tw'(SWEEP_CYC - 1);
    localparam logic [RAIN_W-1:0] c_th_slow   = RAIN_W'(TH_SLOW);
    localparam logic [RAIN_W-1:0] c_th_fast   = RAIN_W'(TH_FAST);

    wiper_state_t    r_state, w_state_nxt, w_end_state;
    logic            r_fast, w_fast_nxt, w_end_fast;
    logic            r_arm;
    logic [1:0]      r_motor;
    logic            r_busy;
    logic            w_tmr_load, w_end_load, w_tmr_done;
    logic [c_tw-1:0] w_tmr_val, w_end_val, w_gap_last, w_unused_tmr_value;
    logic [31:0]     w_gap_cycles;
    logic            w_demand, w_cont, w_gap_ok, w_spd_fast, w_single_req, w_single_take;
    logic            w_wash_end;

`ifdef WIPER_WASH_EN
    localparam int c_dw = (DRY_SWEEPS < 1) ? 1 : $clog2(DRY_SWEEPS + 1);
    localparam logic [c_dw-1:0] c_dry_first = c_dw'((DRY_SWEEPS < 1) ? 0 : DRY_SWEEPS - 1);
    logic [c_dw-1:0] r_dry_left, w_dry_nxt;
    logic            r_pump;
    assign w_wash_end = wash;
`else
    localparam int c_unused_dry = DRY_SWEEPS;
    logic w_unused_wash;
    assign w_unused_wash = wash;
    assign w_wash_end    = 1'b0;
`endif

    // Demand decode: any wiping request, continuous request and the intermittent band
    assign w_demand   = en && (auto_md ? (rain != '0) : (man_spd == 2'd1 || man_spd == 2'd2));
    assign w_cont     = en && (auto_md ? (rain >= c_th_slow) : (man_spd == 2'd1 || man_spd == 2'd2));
    assign w_gap_ok   = en && auto_md && (rain != '0) && (rain < c_th_slow);
    assign w_spd_fast = auto_md ? (rain >= c_th_fast) : (man_spd == 2'd2);
    assign w_single_req = r_arm && en && !auto_md && (man_spd == 2'd3);

    // Gap length computed only inside the intermittent band so the subtraction cannot wrap
    always_comb begin
        w_gap_cycles = 32'd0;
        if (w_gap_ok) begin
            w_gap_cycles = (32'(c_th_slow) - 32'(rain)) * 32'(GAP_STEP);
        end
        w_gap_last = (w_gap_cycles == 32'd0) ? '0 : c_tw'(w_gap_cycles - 32'd1);
    end

    // Where the FSM goes when a sweep finishes without a pending dry sweep
    always_comb begin
        w_end_state = ST_IDLE;
        w_end_fast  = r_fast;
        w_end_load  = 1'b0;
        w_end_val   = c_sweep_val;
        if (w_wash_end) begin
            w_end_state = ST_WASH;
            w_end_load  = 1'b1;
        end else if (w_cont) begin
            w_end_state = ST_WIPE;
            w_end_fast  = w_spd_fast;
            w_end_load  = 1'b1;
        end else if (w_gap_ok) begin
            w_end_state = ST_GAP;
            w_end_load  = 1'b1;
            w_end_val   = w_gap_last;
        end
    end

    // Next-state logic; every timer load coincides with a state entry or sweep restart
    always_comb begin
        w_state_nxt   = r_state;
        w_fast_nxt    = r_fast;
        w_tmr_load    = 1'b0;
        w_tmr_val     = c_sweep_val;
        w_single_take = 1'b0;
`ifdef WIPER_WASH_EN
        w_dry_nxt     = r_dry_left;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef WIPER_WASH_EN
                if (en && wash) begin
                    w_state_nxt = ST_WASH;
                    w_tmr_load  = 1'b1;
                end else
`endif
                if (w_demand || w_single_req) begin
                    w_state_nxt   = ST_WIPE;
                    w_fast_nxt    = w_spd_fast;
                    w_tmr_load    = 1'b1;
                    w_single_take = w_single_req;
                end
            end
            ST_WIPE: begin
                if (w_tmr_done) begin
                    w_state_nxt = w_end_state;
                    w_fast_nxt  = w_end_fast;
                    w_tmr_load  = w_end_load;
                    w_tmr_val   = w_end_val;
                end
            end
            ST_GAP: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
`ifdef WIPER_WASH_EN
                end else if (wash) begin
                    w_state_nxt = ST_WASH;
                    w_tmr_load  = 1'b1;
`endif
                end else if ((auto_md && (rain >= c_th_slow)) || (w_tmr_done && w_demand)) begin
                    w_state_nxt = ST_WIPE;
                    w_fast_nxt  = w_spd_fast;
                    w_tmr_load  = 1'b1;
                end else if (w_tmr_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef WIPER_WASH_EN
            ST_WASH: begin
                if (w_tmr_done) begin
                    w_tmr_load = 1'b1;
                    if (!wash) begin
                        w_state_nxt = ST_DRY;
                        w_dry_nxt   = c_dry_first;
                    end
                end
            end
            ST_DRY: begin
                if (w_tmr_done) begin
                    if (wash) begin
                        w_state_nxt = ST_WASH;
                        w_tmr_load  = 1'b1;
                    end else if (r_dry_left != '0) begin
                        w_dry_nxt  = r_dry_left - 1'b1;
                        w_tmr_load = 1'b1;
                    end else begin
                        w_state_nxt = w_end_state;
                        w_fast_nxt  = w_end_fast;
                        w_tmr_load  = w_end_load;
                        w_tmr_val   = w_end_val;
                    end
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    wiper_timer #(
        .W (c_tw)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_value    (w_unused_tmr_value),
        .o_done     (w_tmr_done)
    );

    // State, speed latch and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_fast  <= 1'b0;
            r_motor <= MOT_OFF;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fast  <= w_fast_nxt;
            r_motor <= motor_code(w_state_nxt, w_fast_nxt);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Single-sweep arm: re-armed whenever man_spd is away from 3, spent when a sweep starts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arm <= 1'b0;
        end else if (man_spd != 2'd3) begin
            r_arm <= 1'b1;
        end else if (w_single_take) begin
            r_arm <= 1'b0;
        end
    end

`ifdef WIPER_WASH_EN
    // Pump follows the washer request only while in WASH; dry-sweep countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pump     <= 1'b0;
            r_dry_left <= '0;
        end else begin
            r_pump     <= (w_state_nxt == ST_WASH) && wash;
            r_dry_left <= w_dry_nxt;
        end
    end
    assign pump = r_pump;
`else
    assign pump = 1'b0;
`endif

    assign motor = r_motor;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_car_wiper_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_car_wiper_ctrl
//  Description : Directed scoreboard bench for car_wiper_ctrl. Each clock the
//                driver queues the outputs expected after that edge; a monitor
//                on the falling edge pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_car_wiper_ctrl;
    import car_wiper_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       auto_md;
    logic [1:0] man_spd;
    logic [3:0] rain;
    logic       wash;
    logic [1:0] motor;
    logic       pump;
    logic       busy;

    logic [3:0] q_exp[$];
    int         q_tag[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         sc    = 0;

    always #5 clk = ~clk;

    car_wiper_ctrl #(
        .SWEEP_CYC  (8),
        .RAIN_W     (4),
        .TH_SLOW    (8),
        .TH_FAST    (12),
        .GAP_STEP   (4),
        .DRY_SWEEPS (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .auto_md (auto_md),
        .man_spd (man_spd),
        .rain    (rain),
        .wash    (wash),
        .motor   (motor),
        .pump    (pump),
        .busy    (busy)
    );

    // Advance n edges, queueing the outputs expected after each edge
    task automatic tick(input int n, input logic [1:0] m, input logic p, input logic b);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            q_exp.push_back({m, p, b});
            q_tag.push_back(sc);
            #1;
        end
    endtask

    // Monitor: compare DUT outputs with the queued expectation on every falling edge
    initial begin
        logic [3:0] exp_v;
        int         tag;
        forever begin
            @(negedge clk);
            if (q_exp.size() != 0) begin
                exp_v = q_exp.pop_front();
                tag   = q_tag.pop_front();
                n_cmp++;
                if ({motor, pump, busy} !== exp_v) begin
                    n_bad++;
                    $display("FAIL sc%0d t=%0t motor/pump/busy got %b/%b/%b want %b/%b/%b",
                             tag, $time, motor, pump, busy, exp_v[3:2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst = 1'b1; en = 1'b0; auto_md = 1'b0; man_spd = 2'd0; rain = 4'd0; wash = 1'b0;
        sc = 0;
        tick(2, MOT_OFF, 1'b0, 1'b0);

        // Manual fast from the first cycle out of reset, change speed, then stop mid-sweep
        sc = 1;
        rst = 1'b0; en = 1'b1; man_spd = 2'd2;
        tick(11, MOT_FAST, 1'b0, 1'b1);
        man_spd = 2'd1;
        tick(5, MOT_FAST, 1'b0, 1'b1);
        tick(3, MOT_SLOW, 1'b0, 1'b1);
        man_spd = 2'd0;
        tick(5, MOT_SLOW, 1'b0, 1'b1);
        tick(2, MOT_OFF, 1'b0, 1'b0);

        // Auto intermittent rain=6: 8 wipe, 8 gap; heavy rain in gap wipes fast at once
        sc = 2;
        auto_md = 1'b1; rain = 4'd6;
        tick(8, MOT_SLOW, 1'b0, 1'b1);
        tick(8, MOT_OFF, 1'b0, 1'b1);
        tick(8, MOT_SLOW, 1'b0, 1'b1);
        tick(3, MOT_OFF, 1'b0, 1'b1);
        rain = 4'd13;
        tick(2, MOT_FAST, 1'b0, 1'b1);
        rain = 4'd0;
        tick(6, MOT_FAST, 1'b0, 1'b1);
        tick(2, MOT_OFF, 1'b0, 1'b0);

        // Light rain: long gap aborted by en=0 on the next cycle
        sc = 3;
        rain = 4'd2;
        tick(8, MOT_SLOW, 1'b0, 1'b1);
        tick(2, MOT_OFF, 1'b0, 1'b1);
        en = 1'b0;
        tick(2, MOT_OFF, 1'b0, 1'b0);
        rain = 4'd0; en = 1'b1; auto_md = 1'b0;

        // Single sweep: held at 3 gives one sweep; leaving and returning re-arms
        sc = 4;
        man_spd = 2'd3;
        tick(8, MOT_SLOW, 1'b0, 1'b1);
        tick(32, MOT_OFF, 1'b0, 1'b0);
        man_spd = 2'd0;
        tick(1, MOT_OFF, 1'b0, 1'b0);
        man_spd = 2'd3;
        tick(8, MOT_SLOW, 1'b0, 1'b1);
        man_spd = 2'd0;
        tick(2, MOT_OFF, 1'b0, 1'b0);

        // Washer pulse of 3 cycles from IDLE
        sc = 5;
        wash = 1'b1;
`ifdef WIPER_WASH_EN
        tick(3, MOT_SLOW, 1'b1, 1'b1);
        wash = 1'b0;
        tick(5, MOT_SLOW, 1'b0, 1'b1);
        tick(16, MOT_SLOW, 1'b0, 1'b1);
        tick(2, MOT_OFF, 1'b0, 1'b0);
`else
        tick(3, MOT_OFF, 1'b0, 1'b0);
        wash = 1'b0;
        tick(2, MOT_OFF, 1'b0, 1'b0);
`endif

        // Reset at cycle 4 of a fast sweep, then restart immediately after release
        sc = 6;
        man_spd = 2'd2;
        tick(4, MOT_FAST, 1'b0, 1'b1);
        rst = 1'b1;
        tick(1, MOT_OFF, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1, MOT_FAST, 1'b0, 1'b1);
        man_spd = 2'd0;
        tick(7, MOT_FAST, 1'b0, 1'b1);
        tick(1, MOT_OFF, 1'b0, 1'b0);

        // Reset clears the single-sweep arm: man_spd held at 3 across reset does nothing
        sc = 7;
        rst = 1'b1; man_spd = 2'd3;
        tick(1, MOT_OFF, 1'b0, 1'b0);
        rst = 1'b0;
        tick(3, MOT_OFF, 1'b0, 1'b0);
        man_spd = 2'd0;
        tick(1, MOT_OFF, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        if (q_exp.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
